inst_fetch_req: RTL

- Pre-IF fetch front end that owns the fetch PC.
- Issues instruction reads on an SRAM-like request/response bus (req/addr_ok, data_ok).
- Tracks in-flight requests and discards responses that a redirect has made stale.
- Buffers returned {inst, pc} pairs in a small FIFO and hands them to the IF stage with a valid/allowin handshake. Replaces the single-cycle synchronous inst SRAM path.

---
 rtl/inst_fetch_req.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_req.sv
// Pre-IF fetch front end: owns the fetch PC, issues reads on an SRAM-like req/addr_ok/data_ok
// bus, drops stale responses after redirects and buffers {adef, inst, pc} for IF. Optional: INST_FETCH_ADEF_CHECK_EN.
module inst_fetch_req #(
    parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] br_bus,
    input  logic        WB_EXC_signal,
    input  logic        WB_ERTN_signal,
    input  logic [31:0] CSR_2_IF_pc,
    input  logic        IF_allowin,
    output logic        fetch_IF_valid,
    output logic [64:0] fetch_IF_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      fetch_pc;
    logic [2:0]       outstanding;
    logic [2:0]       discard_cnt;
    logic [1:0]       pcq_head;
    logic [1:0]       pcq_tail;
    logic [31:0]      pcq [0:3];
    logic [64:0]      fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] fifo_head;
    logic [PTR_W-1:0] fifo_tail;
    logic [CNT_W-1:0] fifo_count;

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        credit_ok;
    logic        fetch_ok;
    logic        accept;
    logic        ret;
    logic        keep;
    logic        adef_push;
    logic        fifo_push;
    logic        fifo_pop;
    logic [64:0] push_entry;

    function automatic logic [1:0] pcq_next(input logic [1:0] p);
        return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign br_taken    = br_bus[32];
    assign br_target   = br_bus[31:0];
    assign redirect    = WB_EXC_signal | WB_ERTN_signal | br_taken;
    assign redirect_pc = (WB_EXC_signal | WB_ERTN_signal) ? CSR_2_IF_pc : br_target;

    // Credit covers in-flight plus buffered entries, so every response is guaranteed a FIFO slot.
    assign credit_ok = (outstanding < 3'(MAX_OUTSTANDING)) &&
                       ((5'(outstanding) + 5'(fifo_count)) < 5'(FIFO_DEPTH));

`ifdef INST_FETCH_ADEF_CHECK_EN
    logic adef_stall;
    logic pc_misaligned;

    assign pc_misaligned = fetch_pc[1:0] != 2'b00;
    assign fetch_ok      = ~pc_misaligned & ~adef_stall;
    // Wait for older (discarded) requests to drain so the fault entry is not overtaken.
    assign adef_push     = ~reset & ~redirect & pc_misaligned & ~adef_stall &
                           (outstanding == 3'd0) & (fifo_count < DEPTH_C);

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            adef_stall <= 1'b0;
        end else if (adef_push) begin
            adef_stall <= 1'b1;
        end
    end
`else
    assign fetch_ok  = 1'b1;
    assign adef_push = 1'b0;
`endif

    assign inst_sram_req   = ~reset & ~redirect & credit_ok & fetch_ok;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'h0;

    assign accept     = inst_sram_req & inst_sram_addr_ok;
    assign ret        = inst_sram_data_ok & (outstanding != 3'd0);
    assign keep       = ret & (discard_cnt == 3'd0) & ~redirect;
    assign fifo_push  = keep | adef_push;
    assign push_entry = adef_push ? {1'b1, 32'h0, fetch_pc}
                                  : {1'b0, inst_sram_rdata, pcq[pcq_head]};

    assign fetch_IF_valid = ~reset & ~redirect & (fifo_count != '0);
    assign fetch_IF_bus   = fifo_mem[fifo_head];
    assign fifo_pop       = fetch_IF_valid & IF_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 3'd0;
            discard_cnt <= 3'd0;
            pcq_head    <= 2'd0;
            pcq_tail    <= 2'd0;
            fifo_head   <= '0;
            fifo_tail   <= '0;
            fifo_count  <= '0;
        end else begin
            if (accept) begin
                pcq_tail <= pcq_next(pcq_tail);
            end
            if (ret) begin
                pcq_head <= pcq_next(pcq_head);
            end
            if (accept && !ret) begin
                outstanding <= outstanding + 3'd1;
            end else if (!accept && ret) begin
                outstanding <= outstanding - 3'd1;
            end

            if (redirect) begin
                // Everything still in flight after this cycle's return belongs to the old path.
                fetch_pc    <= redirect_pc;
                discard_cnt <= outstanding - {2'b00, ret};
                fifo_head   <= '0;
                fifo_tail   <= '0;
                fifo_count  <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (ret && discard_cnt != 3'd0) begin
                    discard_cnt <= discard_cnt - 3'd1;
                end
                if (fifo_push) begin
                    fifo_tail <= fifo_tail + PTR_W'(1);
                end
                if (fifo_pop) begin
                    fifo_head <= fifo_head + PTR_W'(1);
                end
                if (fifo_push && !fifo_pop) begin
                    fifo_count <= fifo_count + CNT_W'(1);
                end else if (!fifo_push && fifo_pop) begin
                    fifo_count <= fifo_count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pcq[pcq_tail] <= fetch_pc;
        end
        if (fifo_push) begin
            fifo_mem[fifo_tail] <= push_entry;
        end
    end

endmodule
